// File: rtl/yarvi_commit_if.sv
// Commit-stage bus: retirement records in from the memory stage, back-pressure
// out, and the valid/ready trace port draining the retirement FIFO.
//   in_*      : retiring instruction (valid, priv, pc, insn, rd, value)
//   stall     : pipeline hold request from the commit stage
//   tr_*      : head retirement record and its valid/ready handshake
// Modports: master = pipeline/tracer side, slave = commit stage.
interface yarvi_commit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned VLEN = 64
);
  logic            in_valid;
  logic [1:0]      in_priv;
  logic [VLEN-1:0] in_pc;
  logic [31:0]     in_insn;
  logic [4:0]      in_wb_rd;
  logic [XLEN-1:0] in_wb_val;
  logic            stall;

  logic            tr_valid;
  logic            tr_ready;
  logic [1:0]      tr_priv;
  logic [VLEN-1:0] tr_pc;
  logic [31:0]     tr_insn;
  logic [4:0]      tr_wb_rd;
  logic [XLEN-1:0] tr_wb_val;

  modport master (
    output in_valid, in_priv, in_pc, in_insn, in_wb_rd, in_wb_val,
    output tr_ready,
    input  stall,
    input  tr_valid, tr_priv, tr_pc, tr_insn, tr_wb_rd, tr_wb_val
  );

  modport slave (
    input  in_valid, in_priv, in_pc, in_insn, in_wb_rd, in_wb_val,
    input  tr_ready,
    output stall,
    output tr_valid, tr_priv, tr_pc, tr_insn, tr_wb_rd, tr_wb_val
  );
endinterface

// File: rtl/yarvi_commit.sv
// yarvi writeback/commit stage. Counts architectural retirements and buffers
// retirement records in a DEPTH-entry FIFO drained over the trace port.
// MODE=0: lossy, records arriving with no free slot are dropped and counted.
// MODE=1: back-pressure, stall is raised while the FIFO is full.
// Ports:
//   clock   : sole clock, rising edge
//   reset   : asynchronous, active-high, clears pointers and counters
//   cif     : commit bus (in_*, stall, tr_*), slave side
//   instret : 64-bit retired-instruction counter (wraps)
//   dropped : 16-bit saturating count of records lost to overflow
module yarvi_commit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned VLEN  = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  yarvi_commit_if.slave        cif,
  output logic [63:0]          instret,
  output logic [15:0]          dropped
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RW = 2 + VLEN + 32 + 5 + XLEN;
  localparam bit          LOSSY = (MODE == 0);

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  logic [PW-1:0] count_c;
  logic          empty_c;
  logic          full_c;
  logic          pop_c;
  logic          space_c;
  logic          push_c;
  logic          retire_c;
  logic          drop_c;

  // Occupancy, handshake and accept/drop decisions for this cycle.
  always_comb begin
    count_c  = wptr - rptr;
    empty_c  = (count_c == PW'(0));
    full_c   = (count_c == PW'(DEPTH));
    pop_c    = !empty_c && cif.tr_ready;
    space_c  = !full_c || pop_c;
    retire_c = 1'b0;
    push_c   = 1'b0;
    drop_c   = 1'b0;
    if (LOSSY) begin
      retire_c = cif.in_valid;
      push_c   = cif.in_valid && space_c;
      drop_c   = cif.in_valid && !space_c;
    end else begin
      // Only full blocks here; using pop would put tr_ready on the stall path.
      retire_c = cif.in_valid && !full_c;
      push_c   = retire_c;
    end
  end

  assign cif.stall    = LOSSY ? 1'b0 : full_c;
  assign cif.tr_valid = !empty_c;
  assign {cif.tr_priv, cif.tr_pc, cif.tr_insn, cif.tr_wb_rd, cif.tr_wb_val} =
         mem[rptr[AW-1:0]];

  // Pointers and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      instret <= '0;
      dropped <= '0;
    end else begin
      if (push_c) begin
        wptr <= wptr + PW'(1);
      end
      if (pop_c) begin
        rptr <= rptr + PW'(1);
      end
      if (retire_c) begin
        instret <= instret + 64'd1;
      end
      if (drop_c && (dropped != 16'hFFFF)) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

  // Record storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wptr[AW-1:0]] <= {cif.in_priv, cif.in_pc, cif.in_insn,
                            cif.in_wb_rd, cif.in_wb_val};
    end
  end
endmodule

// File: tb/tb_yarvi_commit.sv
module tb_yarvi_commit;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned VLEN  = 64;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [1:0]      priv;
    logic [VLEN-1:0] pc;
    logic [31:0]     insn;
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } rec_t;

  logic        clock;
  logic        reset;
  logic [63:0] instret0, instret1;
  logic [15:0] dropped0, dropped1;

  yarvi_commit_if #(.XLEN(XLEN), .VLEN(VLEN)) if0 ();
  yarvi_commit_if #(.XLEN(XLEN), .VLEN(VLEN)) if1 ();

  yarvi_commit #(.XLEN(XLEN), .VLEN(VLEN), .DEPTH(DEPTH), .MODE(0)) dut0 (
    .clock(clock), .reset(reset), .cif(if0),
    .instret(instret0), .dropped(dropped0)
  );
  yarvi_commit #(.XLEN(XLEN), .VLEN(VLEN), .DEPTH(DEPTH), .MODE(1)) dut1 (
    .clock(clock), .reset(reset), .cif(if1),
    .instret(instret1), .dropped(dropped1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_cmp;
  int          n_bad;
  rec_t        sb0[$];
  rec_t        sb1[$];
  int          m_count[2];
  logic [63:0] m_instret[2];
  logic [15:0] m_dropped[2];
  logic        prev_hold[2];
  rec_t        prev_hd[2];
  logic        cur_v;
  logic        cur_rdy;
  rec_t        cur_r;

  task automatic cmp(input string name, input int m, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, m, act, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.priv = 2'($urandom);
    r.pc   = {$urandom, $urandom};
    r.insn = $urandom;
    r.rd   = 5'($urandom);
    r.val  = {$urandom, $urandom};
    return r;
  endfunction

  task automatic model_clear();
    sb0.delete();
    sb1.delete();
    for (int m = 0; m < 2; m++) begin
      m_count[m]   = 0;
      m_instret[m] = '0;
      m_dropped[m] = '0;
      prev_hold[m] = 1'b0;
      prev_hd[m]   = '0;
    end
  endtask

  // Reference model: a bounded queue plus counters, advanced once per edge.
  task automatic step_model();
    for (int m = 0; m < 2; m++) begin
      bit full, pop, space;
      full  = (m_count[m] == int'(DEPTH));
      pop   = (m_count[m] > 0) && cur_rdy;
      space = !full || pop;
      if (pop) m_count[m]--;
      if (m == 0) begin
        if (cur_v) begin
          m_instret[0] = m_instret[0] + 64'd1;
          if (space) begin
            sb0.push_back(cur_r);
            m_count[0]++;
          end else if (m_dropped[0] != 16'hFFFF) begin
            m_dropped[0] = m_dropped[0] + 16'd1;
          end
        end
      end else if (cur_v && !full) begin
        sb1.push_back(cur_r);
        m_count[1]++;
        m_instret[1] = m_instret[1] + 64'd1;
      end
    end
  endtask

  task automatic set_inputs(input logic v, input logic rdy, input rec_t r);
    cur_v = v;  cur_rdy = rdy;  cur_r = r;
    if0.in_valid = v;  if0.in_priv = r.priv;  if0.in_pc = r.pc;
    if0.in_insn = r.insn;  if0.in_wb_rd = r.rd;  if0.in_wb_val = r.val;
    if0.tr_ready = rdy;
    if1.in_valid = v;  if1.in_priv = r.priv;  if1.in_pc = r.pc;
    if1.in_insn = r.insn;  if1.in_wb_rd = r.rd;  if1.in_wb_val = r.val;
    if1.tr_ready = rdy;
  endtask

  task automatic drive(input logic v, input logic rdy, input rec_t r);
    set_inputs(v, rdy, r);
    @(posedge clock);
    #1;
    step_model();
  endtask

  // Monitor side: compare the head against the scoreboard and pop on handshake.
  task automatic check_inst(input int m, input logic tv, input rec_t hd,
                            input logic rdy, input logic st,
                            input logic [63:0] ir, input logic [15:0] dr);
    int   sz;
    rec_t exp_hd;
    sz = (m == 0) ? sb0.size() : sb1.size();
    cmp("tr_valid", m, 256'(tv), 256'(sz != 0));
    if (tv && sz != 0) begin
      exp_hd = (m == 0) ? sb0[0] : sb1[0];
      cmp("head_record", m, 256'(hd), 256'(exp_hd));
    end
    if (prev_hold[m] && tv) cmp("hold_stable", m, 256'(hd), 256'(prev_hd[m]));
    prev_hold[m] = tv && !rdy;
    prev_hd[m]   = hd;
    if (tv && rdy && sz != 0) begin
      if (m == 0) void'(sb0.pop_front());
      else        void'(sb1.pop_front());
    end
    cmp("stall", m, 256'(st), 256'((m == 1) && (m_count[m] == int'(DEPTH))));
    cmp("instret", m, 256'(ir), 256'(m_instret[m]));
    cmp("dropped", m, 256'(dr), 256'(m_dropped[m]));
  endtask

  initial begin
    forever begin
      @(negedge clock);
      check_inst(0, if0.tr_valid,
                 {if0.tr_priv, if0.tr_pc, if0.tr_insn, if0.tr_wb_rd, if0.tr_wb_val},
                 if0.tr_ready, if0.stall, instret0, dropped0);
      check_inst(1, if1.tr_valid,
                 {if1.tr_priv, if1.tr_pc, if1.tr_insn, if1.tr_wb_rd, if1.tr_wb_val},
                 if1.tr_ready, if1.stall, instret1, dropped1);
    end
  end

  initial begin
    rec_t r;
    rec_t idle;
    n_cmp = 0;
    n_bad = 0;
    idle  = '0;
    model_clear();
    reset = 1'b1;
    set_inputs(1'b0, 1'b0, idle);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // First retirement after reset.
    r = '{priv: 2'd3, pc: 64'h1000, insn: 32'h00100093, rd: 5'd1, val: 64'd1};
    drive(1'b1, 1'b0, r);
    cmp("first_valid", 0, 256'(if0.tr_valid), 256'(1'b1));
    cmp("first_pc", 0, 256'(if0.tr_pc), 256'(64'h1000));
    cmp("first_insn", 0, 256'(if0.tr_insn), 256'(32'h00100093));
    cmp("first_rd", 0, 256'(if0.tr_wb_rd), 256'(5'd1));
    cmp("first_val", 0, 256'(if0.tr_wb_val), 256'(64'd1));
    cmp("first_instret", 0, 256'(instret0), 256'(64'd1));
    cmp("first_pc", 1, 256'(if1.tr_pc), 256'(64'h1000));
    repeat (3) drive(1'b0, 1'b1, idle);

    // Six pushes into a blocked consumer.
    repeat (6) drive(1'b1, 1'b0, rand_rec());
    cmp("ovf_instret", 0, 256'(instret0), 256'(64'd7));
    cmp("ovf_dropped", 0, 256'(dropped0), 256'(16'd2));
    cmp("ovf_instret", 1, 256'(instret1), 256'(64'd5));
    cmp("ovf_dropped", 1, 256'(dropped1), 256'(16'd0));
    cmp("ovf_stall", 1, 256'(if1.stall), 256'(1'b1));

    // Push and pop together on a full FIFO.
    drive(1'b1, 1'b1, rand_rec());
    cmp("fullpp_dropped", 0, 256'(dropped0), 256'(16'd2));
    cmp("fullpp_instret", 0, 256'(instret0), 256'(64'd8));
    cmp("fullpp_instret", 1, 256'(instret1), 256'(64'd5));
    cmp("fullpp_stall", 1, 256'(if1.stall), 256'(1'b0));
    drive(1'b1, 1'b1, rand_rec());
    cmp("resume_instret", 1, 256'(instret1), 256'(64'd6));
    repeat (8) drive(1'b0, 1'b1, idle);

    // Twenty records with the consumer toggling.
    for (int i = 0; i < 20; i++) drive(1'b1, (i % 2) == 0, rand_rec());
    repeat (8) drive(1'b0, 1'b1, idle);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_rec());
    repeat (8) drive(1'b0, 1'b1, idle);

    // instret wrap.
    force dut0.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instret[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut0.instret;
    drive(1'b1, 1'b1, rand_rec());
    cmp("instret_wrap", 0, 256'(instret0), 256'(64'd0));

    // dropped saturation.
    repeat (4) drive(1'b1, 1'b0, rand_rec());
    force dut0.dropped = 16'hFFFF;
    m_dropped[0] = 16'hFFFF;
    #1;
    release dut0.dropped;
    drive(1'b1, 1'b0, rand_rec());
    cmp("dropped_sat", 0, 256'(dropped0), 256'(16'hFFFF));
    repeat (8) drive(1'b0, 1'b1, idle);

    // Asynchronous reset with records queued.
    repeat (3) drive(1'b1, 1'b0, rand_rec());
    #2;
    reset = 1'b1;
    #1;
    cmp("rst_valid", 0, 256'(if0.tr_valid), 256'(1'b0));
    cmp("rst_valid", 1, 256'(if1.tr_valid), 256'(1'b0));
    cmp("rst_instret", 0, 256'(instret0), 256'(64'd0));
    cmp("rst_dropped", 0, 256'(dropped0), 256'(16'd0));
    cmp("rst_stall", 1, 256'(if1.stall), 256'(1'b0));
    model_clear();
    set_inputs(1'b0, 1'b0, idle);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, rand_rec());
    repeat (8) drive(1'b0, 1'b1, idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
